// File: rtl/ttc_pkg.sv
// Shared definitions for the TTC clock-control block: register bit map,
// reset value and a decoded view of the clock control register.
package ttc_pkg;

  localparam int CTRL_W     = 7;

  // Bit positions inside clk_ctrl_reg
  localparam int PS_EN      = 0;
  localparam int PS_VAL_LSB = 1;
  localparam int PS_VAL_MSB = 4;
  localparam int SRC_SEL    = 5;
  localparam int EDGE_SEL   = 6;

  localparam logic [CTRL_W-1:0] CLK_CTRL_RST = 7'h00;

  // Decoded register fields (packed MSB first, matching the bit map above)
  typedef struct packed {
    logic       edge_fall;  // 1 = count falling ext_clk edges
    logic       src_ext;    // 1 = ticks come from ext_clk
    logic [3:0] ps_val;     // divide by 2^(ps_val+1)
    logic       ps_en;      // prescaler enable
  } clk_ctrl_t;

  function automatic clk_ctrl_t decode_ctrl(input logic [CTRL_W-1:0] r);
    clk_ctrl_t c;
    c.ps_en     = r[PS_EN];
    c.ps_val    = r[PS_VAL_MSB:PS_VAL_LSB];
    c.src_ext   = r[SRC_SEL];
    c.edge_fall = r[EDGE_SEL];
    return c;
  endfunction

endpackage

// File: rtl/ttc_ext_clk_sync.sv
// Brings the asynchronous external count clock into the pclk domain and
// produces a one-cycle pulse for each edge of the selected polarity.
// The edge pulse is decoded only from flops, so ext_clk never reaches
// count_en combinationally.
module ttc_ext_clk_sync (
  input  logic pclk,
  input  logic n_p_reset,
  input  logic ext_clk_i,
  input  logic fall_sel_i,
  output logic edge_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // Two-flop synchroniser followed by a history flop. The history flop
  // tracks the synchroniser output every cycle regardless of the selected
  // source, so after a source switch it already holds the current level
  // and no spurious edge is seen.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour, forming a real shift chain.
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= ext_clk_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign edge_o = fall_sel_i ? (hist_q & ~sync2_q) : (sync2_q & ~hist_q);

endmodule

// File: rtl/ttc_clk_ctrl_lite.sv
// Clock control for a TTC counter: holds the clock control register,
// selects the tick source (pclk or synchronised ext_clk edges), applies an
// optional power-of-two prescaler and issues single-cycle count enables.
module ttc_clk_ctrl_lite
  import ttc_pkg::*;
#(
  parameter int PRESC_W = 16
) (
  input  logic              n_p_reset,
  input  logic              pclk,
  input  logic [15:0]       pwdata,
  input  logic              clk_ctrl_reg_sel,
  input  logic              ext_clk,
  input  logic              restart,
  output logic [CTRL_W-1:0] clk_ctrl_reg_out,
  output logic              count_en
);

  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] term;
  logic               ce_q, ce_d;
  logic               pend_q, pend_d;
  clk_ctrl_t          ctrl;
  logic               ext_edge;
  logic               tick;
  logic               restart_req;
  logic               allow_pulse;
  logic               unused_pwdata_hi;

  assign unused_pwdata_hi = ^pwdata[15:CTRL_W];

  assign ctrl = decode_ctrl(ctrl_q);

  ttc_ext_clk_sync u_ext_sync (
    .pclk       (pclk),
    .n_p_reset  (n_p_reset),
    .ext_clk_i  (ext_clk),
    .fall_sel_i (ctrl.edge_fall),
    .edge_o     (ext_edge)
  );

  assign tick = ctrl.src_ext ? ext_edge : 1'b1;

  // Terminal count 2^(N+1)-1; a shift of 16 clears the mask completely,
  // giving all ones for the /65536 setting without needing an extra bit.
  assign term = ~({PRESC_W{1'b1}} << (5'(ctrl.ps_val) + 5'd1));

  // A restart that arrives without a tick is remembered until one arrives.
  assign restart_req = restart | pend_q;

  // In pulsed modes a forced restart pulse must not abut a previous one.
  assign allow_pulse = ~(ce_q & (ctrl.ps_en | ctrl.src_ext));

  // Next-state: register write beats restart, restart beats division.
  // NOTE: every output of this block gets a default first so no path
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    ce_d   = 1'b0;
    pend_d = pend_q;
    if (clk_ctrl_reg_sel) begin
      ctrl_d = pwdata[CTRL_W-1:0];
      cnt_d  = '0;
      pend_d = 1'b0;
    end else if (restart_req) begin
      cnt_d = '0;
      if (tick && allow_pulse) begin
        ce_d   = 1'b1;
        pend_d = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (ctrl.ps_en) begin
      if (tick) begin
        if (cnt_q == term) begin
          cnt_d = '0;
          ce_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + PRESC_W'(1);
        end
      end
    end else begin
      cnt_d = '0;
      ce_d  = tick;
    end
  end

  // State registers; reset discards any partial division.
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      ctrl_q <= CLK_CTRL_RST;
      cnt_q  <= '0;
      ce_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      ce_q   <= ce_d;
      pend_q <= pend_d;
    end
  end

  assign clk_ctrl_reg_out = ctrl_q;
  assign count_en         = ce_q;

endmodule

// File: tb/tb_ttc_clk_ctrl_lite.sv
// Directed bench for ttc_clk_ctrl_lite: a table of prescale settings plus
// hand-written sequences for restart, external edges, long divide and reset.
module tb_ttc_clk_ctrl_lite;

  logic        n_p_reset;
  logic        pclk;
  logic [15:0] pwdata;
  logic        clk_ctrl_reg_sel;
  logic        ext_clk;
  logic        restart;
  logic [6:0]  clk_ctrl_reg_out;
  logic        count_en;

  int n_compared = 0;
  int n_mismatch = 0;

  ttc_clk_ctrl_lite #(.PRESC_W(16)) dut (
    .n_p_reset        (n_p_reset),
    .pclk             (pclk),
    .pwdata           (pwdata),
    .clk_ctrl_reg_sel (clk_ctrl_reg_sel),
    .ext_clk          (ext_clk),
    .restart          (restart),
    .clk_ctrl_reg_out (clk_ctrl_reg_out),
    .count_en         (count_en)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [6:0] wdata;
    int         exp_first;   // edges from write to first count_en
    int         exp_period;  // edges between consecutive count_en
    logic       exp_after;   // count_en one edge after a pulse
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // All driving and sampling happens at negedges, away from the active edge.
  task automatic write_reg(input logic [6:0] d, input logic rst_too);
    clk_ctrl_reg_sel = 1'b1;
    pwdata           = {9'h000, d};
    restart          = rst_too;
    @(negedge pclk);
    clk_ctrl_reg_sel = 1'b0;
    restart          = 1'b0;
  endtask

  // Returns the number of edges until count_en is seen high, or -1.
  task automatic find_pulse(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(negedge pclk);
      if (count_en) begin
        n = i;
        return;
      end
    end
  endtask

  // Drive ext_clk to a new level (sampled on the next edge k); count_en
  // must be high only after edge k+2 when a pulse is expected.
  task automatic ext_step(input logic level, input logic exp_pulse, input string tag);
    ext_clk = level;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check($sformatf("%s_edge%0d", tag, i), int'(count_en),
            (i == 2) ? int'(exp_pulse) : 0);
    end
    @(negedge pclk);
  endtask

  int n;

  initial begin
    vecs[0] = '{7'h00,  1,  1, 1'b1};
    vecs[1] = '{7'h01,  2,  2, 1'b0};
    vecs[2] = '{7'h03,  4,  4, 1'b0};
    vecs[3] = '{7'h05,  8,  8, 1'b0};
    vecs[4] = '{7'h07, 16, 16, 1'b0};
    vecs[5] = '{7'h09, 32, 32, 1'b0};

    n_p_reset        = 1'b0;
    pwdata           = '0;
    clk_ctrl_reg_sel = 1'b0;
    ext_clk          = 1'b0;
    restart          = 1'b0;

    // Reset state
    #1;
    check("rst_readback", int'(clk_ctrl_reg_out), 0);
    check("rst_count_en", int'(count_en), 0);
    repeat (2) @(negedge pclk);
    check("rst_held_count_en", int'(count_en), 0);
    n_p_reset = 1'b1;
    repeat (2) @(negedge pclk);
    check("rel_count_en", int'(count_en), 1);
    @(negedge pclk);
    check("rel_count_en_hold", int'(count_en), 1);

    // Prescale table
    foreach (vecs[v]) begin
      write_reg(vecs[v].wdata, 1'b0);
      check($sformatf("v%0d_readback", v), int'(clk_ctrl_reg_out), int'(vecs[v].wdata));
      check($sformatf("v%0d_write_supp", v), int'(count_en), 0);
      find_pulse(200, n);
      check($sformatf("v%0d_first", v), n, vecs[v].exp_first);
      find_pulse(200, n);
      check($sformatf("v%0d_period", v), n, vecs[v].exp_period);
      @(negedge pclk);
      check($sformatf("v%0d_after", v), int'(count_en), int'(vecs[v].exp_after));
    end

    // Restart at presc_cnt == 5 in /8
    write_reg(7'h05, 1'b0);
    repeat (5) @(negedge pclk);
    check("rs_before", int'(count_en), 0);
    restart = 1'b1;
    @(negedge pclk);
    restart = 1'b0;
    check("rs_forced", int'(count_en), 1);
    find_pulse(20, n);
    check("rs_period1", n, 8);
    find_pulse(20, n);
    check("rs_period2", n, 8);

    // Write and restart together: write wins, no pulse, count from zero
    repeat (3) @(negedge pclk);
    write_reg(7'h05, 1'b1);
    check("wr_rs_readback", int'(clk_ctrl_reg_out), 5);
    check("wr_rs_count_en", int'(count_en), 0);
    find_pulse(20, n);
    check("wr_rs_first", n, 8);

    // External source, rising edges; switch in with ext_clk already high
    write_reg(7'h00, 1'b0);
    ext_clk = 1'b1;
    repeat (4) @(negedge pclk);
    write_reg(7'h20, 1'b0);
    check("ext_r_readback", int'(clk_ctrl_reg_out), 32);
    find_pulse(8, n);
    check("ext_r_no_spurious", n, -1);
    ext_step(1'b0, 1'b0, "ext_r_fall");
    ext_step(1'b1, 1'b1, "ext_r_rise1");
    ext_step(1'b0, 1'b0, "ext_r_fall2");
    ext_step(1'b1, 1'b1, "ext_r_rise2");

    // External source, falling edges
    write_reg(7'h60, 1'b0);
    find_pulse(8, n);
    check("ext_f_no_spurious", n, -1);
    ext_step(1'b0, 1'b1, "ext_f_fall1");
    ext_step(1'b1, 1'b0, "ext_f_rise");
    ext_step(1'b0, 1'b1, "ext_f_fall2");

    // Maximum divide /65536
    write_reg(7'h1F, 1'b0);
    check("n15_readback", int'(clk_ctrl_reg_out), 31);
    find_pulse(70000, n);
    check("n15_first", n, 65536);
    @(negedge pclk);
    check("n15_width", int'(count_en), 0);
    find_pulse(100, n);
    check("n15_no_extra", n, -1);

    // Reset in the middle of a long division
    write_reg(7'h1F, 1'b0);
    repeat (1000) @(negedge pclk);
    #2;
    n_p_reset = 1'b0;
    #1;
    check("mid_rst_readback", int'(clk_ctrl_reg_out), 0);
    check("mid_rst_count_en", int'(count_en), 0);
    @(negedge pclk);
    n_p_reset = 1'b1;
    repeat (2) @(negedge pclk);
    check("mid_rel_count_en", int'(count_en), 1);
    check("mid_rel_readback", int'(clk_ctrl_reg_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
